sprite_scan_reader: RTL
=======================

Name: sprite_scan_reader

Overview:
- Read-side consumer of the 38x40 one-bit-per-pixel sprite ROMs.
- Tracks the VGA raster (1280x1024) and drives the ROM row address.
- Selects the ROM output bit for the current pixel and emits a pipeline-aligned pixel_on mask for the colour mux.
- Sprite position and horizontal flip are double-buffered, so a sprite never tears mid-frame.

Parameters:
- SPR_W, 38, sprite width in pixels (ROM row width).
- SPR_H, 40, sprite height in rows.
- ADDR_W, 6, ROM row-address width; must satisfy 2**ADDR_W >= SPR_H.
- H_ACTIVE, 1280, visible pixels per line.
- V_ACTIVE, 1024, visible lines per frame.
- CW, 11, coordinate width for hcount, vcount and positions.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the first vblank cycle; commits the shadow registers
- pos_valid  in  1  write strobe for the shadow position and flip
- pos_x  in  CW  sprite left column (shadow)
- pos_y  in  CW  sprite top row (shadow)
- flip_h  in  1  mirror horizontally (shadow)
- hcount  in  CW  current raster column
- vcount  in  CW  current raster row
- video_on  in  1  raster is in the active area
- rom_addr  out  ADDR_W  registered ROM row address
- rom_row  in  SPR_W  combinational ROM data; index 0 = leftmost pixel
- pixel_on  out  1  sprite opaque at the pixel presented two cycles earlier
- pixel_valid  out  1  video_on delayed two cycles
- frame_pix_cnt  out  21  opaque pixels drawn in the previous frame

Behaviour:
- Clocking and reset:
  - Single clock clk.
  - Reset is synchronous and active-high on rst.
  - Reset values: rom_addr=0, pixel_on=0, pixel_valid=0, frame_pix_cnt=0; shadow and active pos_x/pos_y=0, flip=0; both pipeline stages cleared.
  - Reset mid-frame: no sprite pixel is output until the next frame_start after rst falls.
- Shadow/active registers:
  - pos_valid=1 loads the shadow registers.
  - frame_start=1 copies shadow to active.
  - If pos_valid and frame_start are high in the same cycle, active takes the incoming pos_x/pos_y/flip_h directly (bypass), and the shadow also loads them.
- Stage 1 (cycle N+1):
  - dy = vcount - act_y and dx = hcount - act_x, each computed CW+1 bits wide so a negative result is detectable.
  - in_box = video_on & (0 <= dy < SPR_H) & (0 <= dx < SPR_W).
  - rom_addr <= dy[ADDR_W-1:0] when in_box, otherwise it holds its previous value.
  - Register col = flip ? SPR_W-1-dx : dx; register in_box and video_on.
- ROM: combinational; rom_row is valid in the same cycle as rom_addr.
- Stage 2 (cycle N+2):
  - pixel_on <= in_box_d & rom_row[col_d].
  - pixel_valid <= video_on_d.
  - Total latency from hcount/vcount to pixel_on is exactly 2 cycles.
- Clipping:
  - Portions of the sprite beyond H_ACTIVE-1 or V_ACTIVE-1 are never output, because video_on is 0 there.
  - act_x > H_ACTIVE-SPR_W is legal: only the visible columns draw.
  - No wrap-around to column 0 or row 0.
- Pixel counter:
  - A 21-bit accumulator increments on each pixel_on=1.
  - On frame_start: frame_pix_cnt <= accumulator; accumulator <= 0, or 1 if a counted pixel coincides with frame_start.
  - The accumulator saturates at all-ones.
- State: two-state frame FSM, WAIT_FRAME -> ACTIVE on frame_start.
  - WAIT_FRAME is entered only from reset.
  - In WAIT_FRAME, in_box is forced to 0.

Decomposition:
- Shared package vga_pkg holds:
  - H_ACTIVE, V_ACTIVE, CW
  - sprite geometry constants SPR_W, SPR_H, ADDR_W
  - a pos_t struct {x, y, flip}
- One natural sub-module: sprite_pos_dbuf, the shadow/active register pair with the bypass rule.

Test Plan:
- Commit and first opaque pixel: rst; pos_x=100, pos_y=200, pos_valid; frame_start; raster at (115,200) then (116,200) -> rom_addr=0; with rom_row 0 (opaque bits 16..23), pixel_on=0 then 1, two cycles later.
- Flip: flip=1, same position, raster (121,200) -> col=16 -> pixel_on=1; raster (122,200) -> col=15 -> pixel_on=0.
- Row 39 reachability: raster (116,239) -> rom_addr=39 -> pixel_on=1; raster (116,240) -> pixel_on=0.
- Edge clip: pos_x=1270; raster columns 1270..1279 draw per ROM; video_on=0 beyond column 1279; no pixel_on at column 0 of the next line.
- Shadow timing: pos_valid mid-frame with x=500 -> drawing stays at x=100 until frame_start; pos_valid coincident with frame_start -> the new position is used that frame.
- Counter and reset: a full frame with the ROM image -> frame_pix_cnt equals the ROM popcount; assert rst mid-frame -> all outputs 0 and no drawing until the next frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - raster and sprite geometry shared by the sprite read path
package vga_pkg;
  localparam int H_ACTIVE = 1280;
  localparam int V_ACTIVE = 1024;
  localparam int CW       = 11;
  localparam int SPR_W    = 38;
  localparam int SPR_H    = 40;
  localparam int ADDR_W   = 6;
  localparam int COL_W    = $clog2(SPR_W);
  localparam int CNT_W    = 21;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          flip;
  } pos_t;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } frame_state_t;
endpackage

// File: rtl/sprite_pos_dbuf.sv
// rtl/sprite_pos_dbuf.sv - shadow/active sprite position pair, committed once per frame
module sprite_pos_dbuf
  import vga_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_commit,
  input  pos_t i_pos,
  output pos_t o_active
);
  pos_t r_shadow;
  pos_t r_active;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (i_load) r_shadow <= i_pos;
      // a write landing on the commit cycle goes straight to active
      if (i_commit) r_active <= i_load ? i_pos : r_shadow;
    end
  end

  assign o_active = r_active;
endmodule

// File: rtl/sprite_scan_reader.sv
// rtl/sprite_scan_reader.sv - raster-tracking sprite ROM reader with 2-cycle pixel mask
module sprite_scan_reader
  import vga_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic              i_pos_valid,
  input  logic [CW-1:0]     i_pos_x,
  input  logic [CW-1:0]     i_pos_y,
  input  logic              i_flip_h,
  input  logic [CW-1:0]     i_hcount,
  input  logic [CW-1:0]     i_vcount,
  input  logic              i_video_on,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [SPR_W-1:0]  i_rom_row,
  output logic              o_pixel_on,
  output logic              o_pixel_valid,
  output logic [CNT_W-1:0]  o_frame_pix_cnt
);
  frame_state_t      r_state;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_in_box;
  logic              r_video_on;
  logic [COL_W-1:0]  r_col;
  logic              r_pixel_on;
  logic              r_pixel_valid;
  logic [CNT_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_frame_cnt;

  pos_t w_pos_in;
  pos_t w_act;

  assign w_pos_in = '{x: i_pos_x, y: i_pos_y, flip: i_flip_h};

  sprite_pos_dbuf u_dbuf (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (i_pos_valid),
    .i_commit (i_frame_start),
    .i_pos    (w_pos_in),
    .o_active (w_act)
  );

  // one extra bit so a raster position left of / above the sprite goes negative
  logic [CW:0] w_dx;
  logic [CW:0] w_dy;
  logic        w_dx_ok;
  logic        w_dy_ok;
  logic        w_in_box;

  assign w_dx     = {1'b0, i_hcount} - {1'b0, w_act.x};
  assign w_dy     = {1'b0, i_vcount} - {1'b0, w_act.y};
  assign w_dx_ok  = !w_dx[CW] && (w_dx < (CW+1)'(SPR_W));
  assign w_dy_ok  = !w_dy[CW] && (w_dy < (CW+1)'(SPR_H));
  assign w_in_box = (r_state == ACTIVE) && i_video_on && w_dx_ok && w_dy_ok;

  logic [COL_W-1:0] w_dx_col;
  logic [COL_W-1:0] w_col;
  logic             w_rom_bit;
  logic [CNT_W-1:0] w_acc_inc;

  assign w_dx_col  = w_dx[COL_W-1:0];
  assign w_col     = w_act.flip ? (COL_W'(SPR_W - 1) - w_dx_col) : w_dx_col;
  assign w_rom_bit = (r_col < COL_W'(SPR_W)) ? i_rom_row[r_col] : 1'b0;
  assign w_acc_inc = (&r_acc) ? r_acc : r_acc + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= WAIT_FRAME;
      r_rom_addr    <= '0;
      r_in_box      <= 1'b0;
      r_video_on    <= 1'b0;
      r_col         <= '0;
      r_pixel_on    <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_acc         <= '0;
      r_frame_cnt   <= '0;
    end else begin
      case (r_state)
        WAIT_FRAME: if (i_frame_start) r_state <= ACTIVE;
        ACTIVE:     r_state <= ACTIVE;
        default:    r_state <= WAIT_FRAME;
      endcase

      if (w_in_box) r_rom_addr <= w_dy[ADDR_W-1:0];
      r_in_box   <= w_in_box;
      r_video_on <= i_video_on;
      r_col      <= w_col;

      r_pixel_on    <= r_in_box & w_rom_bit;
      r_pixel_valid <= r_video_on;

      if (i_frame_start) begin
        r_frame_cnt <= r_acc;
        r_acc       <= r_pixel_on ? CNT_W'(1) : '0;
      end else if (r_pixel_on) begin
        r_acc <= w_acc_inc;
      end
    end
  end

  assign o_rom_addr      = r_rom_addr;
  assign o_pixel_on      = r_pixel_on;
  assign o_pixel_valid   = r_pixel_valid;
  assign o_frame_pix_cnt = r_frame_cnt;
endmodule
